time_set_unit: RTL and testbench
================================

// Module: time_set_unit
// PURPOSE
//  Button-driven time-entry front end for the clock. Produces the BCD overwrite
//  values and the load strobe that the clock block consumes (min_i_o/t, hr_i_o/t, time_ow).
//  Sits between raw push-buttons and the clock/alarm units. Edits are seeded from the running time.
// PARAMETERS
//  DEBOUNCE_CYCLES  4    synchronized input must be stable this many consecutive clk cycles
//  HOLD_CYCLES      16   inc held this long (after the first step) before auto-repeat starts
//  REPEAT_CYCLES    8    auto-repeat period while inc stays held
//  TIMEOUT_CYCLES   256  idle cycles in an edit state before the edit is aborted
//  BLINK_CYCLES     32   half-period of the blink output
// PORTS
//  clk        in   1  single system clock
//  reset      in   1  synchronous, active-high
//  btn_mode   in   1  raw, asynchronous mode button, active-high
//  btn_inc    in   1  raw, asynchronous increment button, active-high
//  cur_min_o  in   4  running-time minutes, ones digit (BCD)
//  cur_min_t  in   4  running-time minutes, tens digit (BCD)
//  cur_hr_o   in   4  running-time hours, ones digit (BCD)
//  cur_hr_t   in   4  running-time hours, tens digit (BCD)
//  min_o      out  4  edited minutes, ones digit (BCD)
//  min_t      out  4  edited minutes, tens digit (BCD)
//  hr_o       out  4  edited hours, ones digit (BCD)
//  hr_t       out  4  edited hours, tens digit (BCD)
//  time_ow    out  1  one-cycle load strobe; the four digit outputs are valid while it is high
//  edit_hr    out  1  high in SET_HR
//  edit_min   out  1  high in SET_MIN
//  blink      out  1  display blink enable for the field under edit; 0 in IDLE
// BEHAVIOUR
//  - Input conditioning: each button passes a 2-FF synchronizer, then a debouncer.
//    - Debounced level changes only after DEBOUNCE_CYCLES identical synchronized samples.
//    - A press event is a 0->1 transition of the debounced level: one cycle, one event per press.
//    - Total latency from raw edge to event = 2 + DEBOUNCE_CYCLES cycles.
//  - Reset: state=IDLE; all digit outputs 0; time_ow, edit_hr, edit_min, blink all 0;
//    debouncers, repeat counter and timeout counter cleared.
//  - FSM: IDLE -> SET_HR -> SET_MIN -> COMMIT -> IDLE.
//    - IDLE: a mode event copies cur_* into the digit registers and moves to SET_HR.
//      Inc events are ignored.
//    - SET_HR: an inc event steps hours. A mode event moves to SET_MIN.
//    - SET_MIN: an inc event steps minutes. A mode event moves to COMMIT.
//    - COMMIT: lasts exactly one cycle with time_ow=1, then IDLE.
//      No other state asserts time_ow.
//  - Hour step (BCD, range 00..23):
//    - 23 -> 00.
//    - hr_o==9 -> hr_o=0, hr_t+1.
//    - Otherwise hr_o+1.
//  - Minute step (BCD, range 00..59):
//    - 59 -> 00, with no carry into hours.
//    - min_o==9 -> min_o=0, min_t+1.
//  - Digit registers update the cycle after the event and hold their value in IDLE.
//  - Auto-repeat: inc held after its press event for HOLD_CYCLES produces one extra step,
//    then one step every REPEAT_CYCLES until release. Release clears the repeat counter.
//  - Simultaneous mode and inc events in the same cycle: mode wins; that inc is discarded.
//  - Timeout counter:
//    - Clears on every event and on every state change.
//    - Reaching TIMEOUT_CYCLES in SET_HR/SET_MIN -> IDLE with no time_ow.
//      Digits keep their edited values.
//  - blink toggles every BLINK_CYCLES while in SET_HR/SET_MIN. It restarts at 1 on entry
//    to each edit state and is forced to 0 in IDLE/COMMIT.
//  - Reset mid-edit: next cycle is IDLE with all outputs at reset values; no strobe.
//  - cur_* changing during an edit has no effect (it is sampled only on IDLE exit).
// TESTING (DEBOUNCE=4, HOLD=16, REPEAT=8, TIMEOUT=256)
//  1. cur=12:34; press mode, 5x inc, mode, 3x inc, mode
//     -> exactly one time_ow pulse, with hr=17, min=37.
//  2. cur=23:59; mode, 1 inc, mode, 1 inc, mode
//     -> time_ow with 00:00; hours are not incremented by the minute wrap.
//  3. btn_inc bounces (pulses of 1-3 cycles) for 20 cycles, then held
//     -> exactly one step; no step occurs before 2+4 cycles of stable high.
//  4. In SET_MIN from 00, hold inc for 16+8*3+2 cycles after its event
//     -> minutes read 05 (1 + 1 + 3 repeats); release stops stepping.
//  5. In SET_HR, no events for 256 cycles
//     -> IDLE, time_ow never asserted, edit_hr=0, blink=0.
//  6. In SET_MIN, assert reset for 1 cycle; separately, mode and inc events on the same cycle
//     -> reset gives IDLE with zeroed outputs and no strobe;
//        the simultaneous events give COMMIT with the minute value unchanged.

Source files
------------

// File: rtl/time_set_unit.sv
// Push-button time entry: debounced mode/inc buttons drive an hour/minute BCD editor
// that emits a one-cycle load strobe for the clock block.
module time_set_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int BLINK_CYCLES    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_min_o,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_hr_o,
  input  logic [3:0] cur_hr_t,
  output logic [3:0] min_o,
  output logic [3:0] min_t,
  output logic [3:0] hr_o,
  output logic [3:0] hr_t,
  output logic       time_ow,
  output logic       edit_hr,
  output logic       edit_min,
  output logic       blink
);

  localparam int NUM_BTN = 2;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = $clog2(RMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SET_HR, SET_MIN, COMMIT} state_t;

  state_t state, state_nx;

  logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_evt;
  assign btn_raw = {btn_inc, btn_mode};

  // Per button: 2-FF synchronizer, then level accepted after DEBOUNCE_CYCLES equal samples.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic [1:0]    sync;
    logic [DW-1:0] cnt;
    logic          lvl, evt;
    always_ff @(posedge clk) begin
      if (reset) begin
        sync <= '0;
        cnt  <= '0;
        lvl  <= 1'b0;
        evt  <= 1'b0;
      end else begin
        sync <= {sync[0], btn_raw[i]};
        evt  <= 1'b0;
        if (sync[1] == lvl) begin
          cnt <= '0;
        end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          lvl <= sync[1];
          evt <= sync[1];
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end
    assign btn_lvl[i] = lvl;
    assign btn_evt[i] = evt;
  end

  logic mode_evt, inc_evt, inc_lvl;
  assign mode_evt = btn_evt[0];
  assign inc_evt  = btn_evt[1];
  assign inc_lvl  = btn_lvl[1];

  // Auto-repeat: first extra step after HOLD_CYCLES, then every REPEAT_CYCLES.
  logic [RW-1:0] rep_cnt;
  logic          rep_phase, rep_step, inc_step, do_inc, any_evt;

  assign rep_step = inc_lvl && !inc_evt &&
                    (rep_cnt == (rep_phase ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1)));
  assign inc_step = inc_evt | rep_step;
  assign do_inc   = inc_step & ~mode_evt;
  assign any_evt  = mode_evt | inc_step;

  always_ff @(posedge clk) begin
    if (reset || !inc_lvl || inc_evt) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_step) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end

  logic [TW-1:0] to_cnt;
  logic          timeout, editing, edit_nx, entering;

  assign editing  = (state == SET_HR) || (state == SET_MIN);
  assign edit_nx  = (state_nx == SET_HR) || (state_nx == SET_MIN);
  assign entering = edit_nx && (state_nx != state);
  assign timeout  = editing && !any_evt && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mode_evt) state_nx = SET_HR;
      SET_HR:  if (mode_evt) state_nx = SET_MIN; else if (timeout) state_nx = IDLE;
      SET_MIN: if (mode_evt) state_nx = COMMIT;  else if (timeout) state_nx = IDLE;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || any_evt || (state_nx != state) || !editing) to_cnt <= '0;
    else                                                     to_cnt <= to_cnt + TW'(1);
  end

  // BCD successors: hours wrap 23->00, minutes wrap 59->00 without carry.
  logic [3:0] hr_o_nx, hr_t_nx, min_o_nx, min_t_nx;
  always_comb begin
    hr_o_nx  = hr_o + 4'd1;
    hr_t_nx  = hr_t;
    min_o_nx = min_o + 4'd1;
    min_t_nx = min_t;
    if (hr_t == 4'd2 && hr_o == 4'd3) begin
      hr_o_nx = 4'd0;
      hr_t_nx = 4'd0;
    end else if (hr_o == 4'd9) begin
      hr_o_nx = 4'd0;
      hr_t_nx = hr_t + 4'd1;
    end
    if (min_t == 4'd5 && min_o == 4'd9) begin
      min_o_nx = 4'd0;
      min_t_nx = 4'd0;
    end else if (min_o == 4'd9) begin
      min_o_nx = 4'd0;
      min_t_nx = min_t + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hr_t  <= '0;
      hr_o  <= '0;
      min_t <= '0;
      min_o <= '0;
    end else begin
      case (state)
        IDLE: if (mode_evt) begin
          hr_t  <= cur_hr_t;
          hr_o  <= cur_hr_o;
          min_t <= cur_min_t;
          min_o <= cur_min_o;
        end
        SET_HR: if (do_inc) begin
          hr_t <= hr_t_nx;
          hr_o <= hr_o_nx;
        end
        SET_MIN: if (do_inc) begin
          min_t <= min_t_nx;
          min_o <= min_o_nx;
        end
        default: ;
      endcase
    end
  end

  // Blink tracks state_nx so it is already 1 in the first cycle of an edit state.
  logic [BW-1:0] bl_cnt;
  always_ff @(posedge clk) begin
    if (reset || !edit_nx) begin
      blink  <= 1'b0;
      bl_cnt <= '0;
    end else if (entering) begin
      blink  <= 1'b1;
      bl_cnt <= '0;
    end else if (bl_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink  <= ~blink;
      bl_cnt <= '0;
    end else begin
      bl_cnt <= bl_cnt + BW'(1);
    end
  end

  assign time_ow  = (state == COMMIT);
  assign edit_hr  = (state == SET_HR);
  assign edit_min = (state == SET_MIN);

endmodule

// File: tb/tb_time_set_unit.sv
// Scenario bench for time_set_unit: button presses are modelled as held durations and the
// expected time is computed with modular hour/minute arithmetic.
module tb_time_set_unit;
  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc;
  logic [3:0] cur_min_o, cur_min_t, cur_hr_o, cur_hr_t;
  logic [3:0] min_o, min_t, hr_o, hr_t;
  logic       time_ow, edit_hr, edit_min, blink;

  int checks = 0, errors = 0;
  int ow_cnt = 0;
  logic [15:0] ow_val = '0;
  logic [15:0] disp;

  time_set_unit dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_min_o(cur_min_o), .cur_min_t(cur_min_t), .cur_hr_o(cur_hr_o), .cur_hr_t(cur_hr_t),
    .min_o(min_o), .min_t(min_t), .hr_o(hr_o), .hr_t(hr_t),
    .time_ow(time_ow), .edit_hr(edit_hr), .edit_min(edit_min), .blink(blink)
  );

  always #5 clk = ~clk;
  assign disp = {hr_t, hr_o, min_t, min_o};

  always @(negedge clk) if (time_ow) begin
    ow_cnt++;
    ow_val = disp;
  end

  function automatic logic [15:0] bcd(int h, int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  // Steps produced by an inc press held for p cycles: the press itself, one after the
  // hold time, then one per repeat period while still held.
  function automatic int steps(int p);
    return ((p - 1) >= 16) ? 2 + (p - 1 - 16) / 8 : 1;
  endfunction

  task automatic set_cur(int h, int m);
    {cur_hr_t, cur_hr_o, cur_min_t, cur_min_o} = bcd(h, m);
  endtask

  task automatic press(bit m, bit i, int p);
    btn_mode = m;
    btn_inc  = i;
    repeat (p) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    set_cur(0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({disp, time_ow, edit_hr, edit_min, blink} !== 20'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 00000", {disp, time_ow, edit_hr, edit_min, blink});
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({disp, time_ow, edit_hr, edit_min, blink} !== 20'h0) begin
      errors++;
      $display("FAIL reset_release: got %h expected 00000", {disp, time_ow, edit_hr, edit_min, blink});
    end
  endtask

  task automatic test_basic;
    int ow0 = ow_cnt;
    set_cur(12, 34);
    press(1, 0, 5);
    repeat (5) press(0, 1, 5);
    checks++;
    if ({edit_hr, hr_t, hr_o} !== 9'h117) begin
      errors++;
      $display("FAIL basic_hours: got %h expected 117", {edit_hr, hr_t, hr_o});
    end
    press(1, 0, 5);
    repeat (3) press(0, 1, 5);
    press(1, 0, 5);
    checks++;
    if (ow_cnt - ow0 !== 1 || ow_val !== 16'h1737) begin
      errors++;
      $display("FAIL basic_commit: got %0d strobes value %h expected 1 strobe value 1737", ow_cnt - ow0, ow_val);
    end
  endtask

  task automatic test_wrap;
    int ow0 = ow_cnt;
    set_cur(23, 59);
    press(1, 0, 5);
    press(0, 1, 5);
    press(1, 0, 5);
    press(0, 1, 5);
    press(1, 0, 5);
    checks++;
    if (ow_cnt - ow0 !== 1 || ow_val !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_commit: got %0d strobes value %h expected 1 strobe value 0000", ow_cnt - ow0, ow_val);
    end
  endtask

  task automatic test_bounce;
    int t = 0, hi, lo;
    bit early = 0;
    set_cur(5, 0);
    press(1, 0, 5);
    while (t < 20) begin
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      btn_inc = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
      btn_inc = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
      if ({hr_t, hr_o} !== 8'h05) early = 1;
      t += hi + lo;
    end
    btn_inc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if ({hr_t, hr_o} !== 8'h05) early = 1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL bounce_early: got early step expected hours 05 until 6 stable cycles");
    end
    repeat (4) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if ({hr_t, hr_o} !== 8'h06) begin
      errors++;
      $display("FAIL bounce_step: got %h expected 06", {hr_t, hr_o});
    end
    press(1, 0, 5);
    press(1, 0, 5);
  endtask

  task automatic test_repeat;
    int ow0 = ow_cnt;
    set_cur(7, 0);
    press(1, 0, 5);
    press(1, 0, 5);
    press(0, 1, 1 + 16 + 8 * 3 + 2);
    checks++;
    if ({edit_min, min_t, min_o} !== 9'h105) begin
      errors++;
      $display("FAIL repeat_count: got %h expected 105", {edit_min, min_t, min_o});
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if ({min_t, min_o} !== 8'h05) begin
      errors++;
      $display("FAIL repeat_release: got %h expected 05", {min_t, min_o});
    end
    press(1, 0, 5);
    checks++;
    if (ow_cnt - ow0 !== 1 || ow_val !== 16'h0705) begin
      errors++;
      $display("FAIL repeat_commit: got %0d strobes value %h expected 1 strobe value 0705", ow_cnt - ow0, ow_val);
    end
  endtask

  task automatic test_timeout;
    int ow0 = ow_cnt;
    set_cur(10, 20);
    press(1, 0, 5);
    press(0, 1, 5);
    repeat (240) @(posedge clk);
    #1;
    checks++;
    if (edit_hr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got edit_hr %b expected 1", edit_hr);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({edit_hr, edit_min, blink} !== 3'b000 || ow_cnt != ow0 || disp !== 16'h1120) begin
      errors++;
      $display("FAIL timeout_abort: got flags %b strobes %0d digits %h expected 000 0 1120",
               {edit_hr, edit_min, blink}, ow_cnt - ow0, disp);
    end
  endtask

  task automatic test_blink;
    int wait_c = 0;
    int ow0 = ow_cnt;
    set_cur(9, 45);
    btn_mode = 1'b1;
    while (edit_hr !== 1'b1 && wait_c < 30) begin
      @(posedge clk);
      #1;
      wait_c++;
    end
    checks++;
    if (edit_hr !== 1'b1 || blink !== 1'b1) begin
      errors++;
      $display("FAIL blink_entry: got edit_hr %b blink %b expected 1 1", edit_hr, blink);
    end
    for (int j = 1; j <= 64; j++) begin
      @(posedge clk);
      #1;
      if (j == 5) btn_mode = 1'b0;
      if (j == 31 || j == 32 || j == 63 || j == 64) begin
        checks++;
        if (blink !== (((j / 32) % 2) == 0)) begin
          errors++;
          $display("FAIL blink_phase_%0d: got %b expected %b", j, blink, ((j / 32) % 2) == 0);
        end
      end
    end
    repeat (8) @(posedge clk);
    #1;
    press(1, 0, 5);
    checks++;
    if ({edit_min, blink} !== 2'b11) begin
      errors++;
      $display("FAIL blink_restart: got %b expected 11", {edit_min, blink});
    end
    press(1, 0, 5);
    checks++;
    if (ow_cnt - ow0 !== 1 || ow_val !== 16'h0945 || blink !== 1'b0) begin
      errors++;
      $display("FAIL blink_commit: got %0d strobes value %h blink %b expected 1 0945 0", ow_cnt - ow0, ow_val, blink);
    end
  endtask

  task automatic test_reset_mid;
    int ow0 = ow_cnt;
    set_cur(14, 15);
    press(1, 0, 5);
    press(1, 0, 5);
    press(0, 1, 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({disp, time_ow, edit_hr, edit_min, blink} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 00000", {disp, time_ow, edit_hr, edit_min, blink});
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ow_cnt != ow0 || disp !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_strobe: got %0d strobes digits %h expected 0 0000", ow_cnt - ow0, disp);
    end
  endtask

  task automatic test_simul;
    int ow0 = ow_cnt;
    int h = $urandom_range(0, 23);
    int m = $urandom_range(0, 59);
    set_cur(h, m);
    press(1, 0, 5);
    press(1, 0, 5);
    press(0, 1, 5);
    press(1, 1, 5);
    checks++;
    if (ow_cnt - ow0 !== 1 || ow_val !== bcd(h, (m + 1) % 60) || edit_min !== 1'b0) begin
      errors++;
      $display("FAIL simul_commit: got %0d strobes value %h edit_min %b expected 1 %h 0",
               ow_cnt - ow0, ow_val, edit_min, bcd(h, (m + 1) % 60));
    end
  endtask

  task automatic test_random;
    int h, m, n, p, ow0;
    for (int it = 0; it < 8; it++) begin
      ow0 = ow_cnt;
      h = $urandom_range(0, 23);
      m = $urandom_range(0, 59);
      set_cur(h, m);
      if ($urandom_range(0, 1) == 1) press(0, 1, $urandom_range(5, 30));
      press(1, 0, 5);
      checks++;
      if (disp !== bcd(h, m) || edit_hr !== 1'b1) begin
        errors++;
        $display("FAIL rand_seed_%0d: got %h edit_hr %b expected %h 1", it, disp, edit_hr, bcd(h, m));
      end
      set_cur($urandom_range(0, 23), $urandom_range(0, 59));
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        p = $urandom_range(5, 60);
        press(0, 1, p);
        h = (h + steps(p)) % 24;
      end
      press(1, 0, 5);
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        p = $urandom_range(5, 60);
        press(0, 1, p);
        m = (m + steps(p)) % 60;
      end
      press(1, 0, 5);
      checks++;
      if (ow_cnt - ow0 !== 1 || ow_val !== bcd(h, m)) begin
        errors++;
        $display("FAIL rand_commit_%0d: got %0d strobes value %h expected 1 %h", it, ow_cnt - ow0, ow_val, bcd(h, m));
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_bounce;
    test_repeat;
    test_timeout;
    test_blink;
    test_reset_mid;
    test_simul;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
